// File: rtl/display_codes_pkg.sv
// Shared display codes, slot width and FSM state encoding for the
// signed digit formatter and the seven-segment decoders it feeds.
package display_codes_pkg;

    localparam int SLOT_W = 5;

    localparam logic [SLOT_W-1:0] CODE_N     = 5'h10;
    localparam logic [SLOT_W-1:0] CODE_MINUS = 5'h11;
    localparam logic [SLOT_W-1:0] CODE_L     = 5'h12;
    localparam logic [SLOT_W-1:0] CODE_P     = 5'h13;
    localparam logic [SLOT_W-1:0] CODE_G     = 5'h14;
    localparam logic [SLOT_W-1:0] CODE_NN    = 5'h15;
    localparam logic [SLOT_W-1:0] CODE_BLANK = 5'h1F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

endpackage

// File: rtl/dabble_adjust.sv
// One BCD nibble correction cell for the double-dabble engine: a nibble
// of 5 or more gets 3 added so the following left shift carries into
// the next decimal digit.
module dabble_adjust (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/signed_digit_formatter.sv
// Converts a two's-complement value into per-digit display codes using a
// one-shift-per-clock double-dabble engine, then formats the digits with
// optional leading-zero blanking and a minus sign. The digit bus is only
// rewritten on the single FORMAT edge, so displays never see partial results.
module signed_digit_formatter
    import display_codes_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WIDTH-1:0]               value_in,
    output logic                           busy,
    output logic                           done,
    output logic [SLOT_W*(DIGITS+1)-1:0]   digits_out
);

    localparam int NIBS  = DIGITS + 1;
    localparam int BCD_W = 4 * NIBS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_t                      state;
    state_t                      next_state;
    logic                        load;
    logic                        shift_en;
    logic                        format_en;
    logic                        sign_q;
    logic [WIDTH-1:0]            bin_q;
    logic [BCD_W-1:0]            bcd_q;
    logic [BCD_W-1:0]            bcd_adj;
    logic [CNT_W-1:0]            cnt_q;
    logic [SLOT_W*NIBS-1:0]      fmt_slots;
    int                          lead;

    for (genvar g = 0; g < NIBS; g++) begin : g_adj
        dabble_adjust u_adj (
            .nibble   (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // State register; reset always returns to IDLE and aborts any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: accept in IDLE, leave SHIFT after the last shift, FORMAT lasts one edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt_q == LAST_SHIFT) next_state = FORMAT;
            FORMAT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control decode: which datapath action happens on the coming edge.
    always_comb begin
        load      = 1'b0;
        shift_en  = 1'b0;
        format_en = 1'b0;
        case (state)
            IDLE:    load      = start;
            SHIFT:   shift_en  = 1'b1;
            FORMAT:  format_en = 1'b1;
            default: ;
        endcase
    end

    // Conversion datapath: capture sign and magnitude, then adjust-and-shift once per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q <= 1'b0;
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sign_q <= value_in[WIDTH-1];
            bin_q  <= value_in[WIDTH-1] ? (~value_in + WIDTH'(1)) : value_in;
            bcd_q  <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q + CNT_W'(1);
        end
    end

    // Formatter: place digits, blank leading zeros if enabled, and position the minus sign.
    always_comb begin
        fmt_slots = {NIBS{CODE_BLANK}};
        lead      = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) lead = k;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (BLANK_ZEROS == 0 || k <= lead) begin
                fmt_slots[SLOT_W*k +: SLOT_W] = {1'b0, bcd_q[4*k +: 4]};
            end
        end
        if (sign_q) begin
            if (BLANK_ZEROS == 0) begin
                fmt_slots[SLOT_W*DIGITS +: SLOT_W] = CODE_MINUS;
            end else if (bcd_q != '0) begin
                fmt_slots[SLOT_W*(lead+1) +: SLOT_W] = CODE_MINUS;
            end
        end
    end

    // Registered outputs: busy tracks the conversion, digits and done change only on FORMAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            digits_out <= {NIBS{CODE_BLANK}};
        end else begin
            busy <= (next_state != IDLE);
            done <= format_en;
            if (format_en) digits_out <= fmt_slots;
        end
    end

endmodule
